// File: rtl/multiphase_clk_gen_if.sv
// rtl/multiphase_clk_gen_if.sv - control and phase-enable bundle for multiphase_clk_gen
interface multiphase_clk_gen_if #(
    parameter int NUM_PHASES = 4,
    parameter int DIV_W      = 8
);
    localparam int IDX_W = $clog2(NUM_PHASES);

    logic                  enable;
    logic [DIV_W-1:0]      div_ratio;
    logic [NUM_PHASES-1:0] phase_o;
    logic [IDX_W-1:0]      phase_idx;
    logic                  tick;
    logic                  wrap;

    modport master (
        output enable, div_ratio,
        input  phase_o, phase_idx, tick, wrap
    );

    modport slave (
        input  enable, div_ratio,
        output phase_o, phase_idx, tick, wrap
    );
endinterface

// File: rtl/multiphase_clk_gen.sv
// rtl/multiphase_clk_gen.sv - one-hot multiphase clock-enable generator; PHASE_GAP_EN inserts a dead cycle between phases
module multiphase_clk_gen #(
    parameter int NUM_PHASES = 4,
    parameter int DIV_W      = 8
) (
    input  logic           clock,
    input  logic           reset,
    multiphase_clk_gen_if.slave bus
);
    localparam int IDX_W = $clog2(NUM_PHASES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PHASES - 1);

    typedef enum logic [1:0] {IDLE, RUN, GAP, PAUSE} state_t;

    state_t           fsm, fsm_d;
    logic [IDX_W-1:0] idx, idx_d;
    logic [DIV_W-1:0] cnt, cnt_d;
    logic [DIV_W-1:0] ratio_q, ratio_d;
    logic [DIV_W-1:0] ratio_in;
    logic [IDX_W-1:0] idx_next;
    logic             tick;
    logic             wrap;

    assign ratio_in = (bus.div_ratio == '0) ? DIV_W'(1) : bus.div_ratio;
    assign idx_next = (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
    assign tick     = (fsm == RUN) && (cnt == ratio_q - DIV_W'(1));
    assign wrap     = tick && (idx == LAST_IDX);

    assign bus.phase_o   = (fsm == RUN) ? (NUM_PHASES'(1) << idx) : '0;
    assign bus.phase_idx = idx;
    assign bus.tick      = tick;
    assign bus.wrap      = wrap;

    always_ff @(posedge clock) begin
        if (reset) begin
            fsm     <= IDLE;
            idx     <= '0;
            cnt     <= '0;
            ratio_q <= DIV_W'(1);
        end else begin
            fsm     <= fsm_d;
            idx     <= idx_d;
            cnt     <= cnt_d;
            ratio_q <= ratio_d;
        end
    end

    always_comb begin
        fsm_d   = fsm;
        idx_d   = idx;
        cnt_d   = cnt;
        ratio_d = ratio_q;
        case (fsm)
            IDLE: begin
                if (bus.enable) begin
                    fsm_d   = RUN;
                    idx_d   = '0;
                    cnt_d   = '0;
                    ratio_d = ratio_in;
                end
            end
            RUN: begin
                if (!bus.enable) begin
                    fsm_d = PAUSE;
                end else if (tick) begin
                    cnt_d = '0;
                    idx_d = idx_next;
                    // Ratio only changes at a period boundary so slots within a period match.
                    if (wrap) begin
                        ratio_d = ratio_in;
                    end
`ifdef PHASE_GAP_EN
                    fsm_d = GAP;
`endif
                end else begin
                    cnt_d = cnt + DIV_W'(1);
                end
            end
            GAP: begin
                fsm_d = bus.enable ? RUN : PAUSE;
            end
            PAUSE: begin
                if (bus.enable) begin
                    fsm_d = RUN;
                end
            end
            default: begin
                fsm_d = IDLE;
            end
        endcase
    end
endmodule
